// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshakes, freeze and flush.
// SKID=1 gives a two-entry skid stage with registered in_ready; SKID=0 a single-entry stage.
module pipe_stage_reg #(
   parameter int               WIDTH       = 64,
   parameter bit               SKID        = 1'b1,
   parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             freeze,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [15:0]      stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [15:0]      stall_cnt_q, stall_cnt_d;
   logic             accept;
   logic             pop;

   assign out_valid = ~freeze & (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign stall_cnt = stall_cnt_q;

   // The skid variant must not look at out_ready, so its in_ready depends on state only.
   always_comb begin
      in_ready = 1'b0;
      if (SKID) begin
         in_ready = ~freeze & (state_q != TWO);
      end else begin
         in_ready = ~freeze & ((state_q == EMPTY) | out_ready);
      end
   end

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = FLUSH_VALUE;
         skid_d  = FLUSH_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_d = in_data;
               end else if (accept && SKID) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // Back-pressure counter ignores flush; freeze already masks out_valid.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_q      <= FLUSH_VALUE;
         skid_q      <= FLUSH_VALUE;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid instance (SKID=1) and a single-entry instance (SKID=0) on one clock.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

   localparam int W = 16;
   localparam logic [W-1:0] FV = 16'hDEAD;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         a_flush = 0, a_freeze = 0, a_in_valid = 0, a_out_ready = 0;
   logic [W-1:0] a_in_data = '0;
   logic         a_in_ready, a_out_valid;
   logic [W-1:0] a_out_data;
   logic [1:0]   a_occ;
   logic [15:0]  a_stall;

   logic         b_flush = 0, b_freeze = 0, b_in_valid = 0, b_out_ready = 0;
   logic [W-1:0] b_in_data = '0;
   logic         b_in_ready, b_out_valid;
   logic [W-1:0] b_out_data;
   logic [1:0]   b_occ;
   logic [15:0]  b_stall;

   pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .FLUSH_VALUE(FV)) dut_a (
      .clk(clk), .rst(rst), .flush(a_flush), .freeze(a_freeze),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   pipe_stage_reg #(.WIDTH(W), .SKID(1'b0), .FLUSH_VALUE('0)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush), .freeze(b_freeze),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] a_q[$];
   logic [W-1:0] b_q[$];
   logic a_clear = 1'b0;
   logic b_clear = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitors: pop the scoreboard on every output handshake.
   always @(negedge clk) begin
      if (!rst && a_out_valid && a_out_ready) begin
         checks++;
         if (a_q.size() == 0) begin
            errors++;
            $display("FAIL a_pop_unexpected actual=%0h required=none", a_out_data);
         end else begin
            logic [W-1:0] e;
            e = a_q.pop_front();
            if (a_out_data !== e) begin
               errors++;
               $display("FAIL a_pop_data actual=%0h required=%0h", a_out_data, e);
            end else begin
               $display("a pop data=%h", a_out_data);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_out_valid && b_out_ready) begin
         checks++;
         if (b_q.size() == 0) begin
            errors++;
            $display("FAIL b_pop_unexpected actual=%0h required=none", b_out_data);
         end else begin
            logic [W-1:0] e;
            e = b_q.pop_front();
            if (b_out_data !== e) begin
               errors++;
               $display("FAIL b_pop_data actual=%0h required=%0h", b_out_data, e);
            end else begin
               $display("b pop data=%h", b_out_data);
            end
         end
      end
   end

   // One cycle of stimulus on stage A; returns at the negedge so the caller can check.
   task automatic a_cyc(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic frz, input logic fl);
      @(posedge clk);
      if (a_clear) a_q.delete();
      #1;
      rst = 1'b0;
      a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_freeze = frz; a_flush = fl;
      @(negedge clk);
      if (v && a_in_ready && !fl) a_q.push_back(d);
      a_clear = fl;
   endtask

   task automatic b_cyc(input logic v, input logic [W-1:0] d, input logic ordy);
      @(posedge clk);
      if (b_clear) b_q.delete();
      #1;
      rst = 1'b0;
      b_in_valid = v; b_in_data = d; b_out_ready = ordy;
      @(negedge clk);
      if (v && b_in_ready) b_q.push_back(d);
      b_clear = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      a_in_valid = 1'b1; a_in_data = 16'hBAD0; a_out_ready = 1'b0; a_flush = 1'b1; a_freeze = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b0;
      @(negedge clk);
      a_clear = 1'b1;
      b_clear = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      // Reset state
      a_cyc(0, 0, 0, 0, 0);
      chk("a_rst_occ", a_occ, 0);
      chk("a_rst_out_valid", a_out_valid, 0);
      chk("a_rst_out_data", a_out_data, FV);
      chk("a_rst_in_ready", a_in_ready, 1);
      chk("a_rst_stall", a_stall, 0);
      chk("b_rst_out_data", b_out_data, 0);

      // Streaming 1..4 with out_ready high
      a_cyc(1, 16'd1, 1, 0, 0);
      chk("a_lat_valid_before", a_out_valid, 0);
      for (int i = 2; i <= 4; i++) begin
         a_cyc(1, W'(i), 1, 0, 0);
         chk("a_stream_occ", a_occ, 1);
         chk("a_stream_data", a_out_data, W'(i - 1));
      end
      a_cyc(0, 0, 1, 0, 0);
      chk("a_stream_last", a_out_data, 4);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_empty_occ", a_occ, 0);
      chk("a_empty_valid", a_out_valid, 0);
      chk("a_empty_hold_data", a_out_data, 4);
      chk("a_stream_stall", a_stall, 0);

      // Back-pressure: A then B held, then drained in order
      a_cyc(1, 16'hA0A0, 0, 0, 0);
      a_cyc(1, 16'hB0B0, 0, 0, 0);
      chk("a_bp_in_ready_one", a_in_ready, 1);
      a_cyc(0, 0, 0, 0, 0);
      chk("a_bp_occ2", a_occ, 2);
      chk("a_bp_in_ready_two", a_in_ready, 0);
      chk("a_bp_stall1", a_stall, 1);
      a_cyc(1, 16'hCCCC, 0, 0, 0);
      chk("a_bp_stall2", a_stall, 2);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_bp_head_a", a_out_data, 16'hA0A0);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_bp_in_ready_after", a_in_ready, 1);
      chk("a_bp_stall3", a_stall, 3);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_bp_drained", a_occ, 0);

      // Freeze holds X
      a_cyc(1, 16'h5A5A, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         a_cyc(1, 16'h1111, 1, 1, 0);
         chk("a_frz_in_ready", a_in_ready, 0);
         chk("a_frz_out_valid", a_out_valid, 0);
         chk("a_frz_data", a_out_data, 16'h5A5A);
         chk("a_frz_stall", a_stall, 3);
      end
      a_cyc(0, 0, 1, 0, 0);
      chk("a_frz_release_valid", a_out_valid, 1);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_frz_occ", a_occ, 0);

      // Flush with freeze and input while full
      a_cyc(1, 16'hC1C1, 0, 0, 0);
      a_cyc(1, 16'hD1D1, 0, 0, 0);
      a_cyc(1, 16'hE1E1, 0, 1, 1);
      chk("a_fl_stall_during", a_stall, 4);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_fl_occ", a_occ, 0);
      chk("a_fl_data", a_out_data, FV);
      chk("a_fl_valid", a_out_valid, 0);
      chk("a_fl_stall", a_stall, 4);

      // SKID=0 stage
      b_cyc(1, 16'h0101, 1);
      chk("b_in_ready_empty", b_in_ready, 1);
      b_cyc(1, 16'h0202, 1);
      chk("b_full_in_ready", b_in_ready, 1);
      chk("b_full_valid", b_out_valid, 1);
      b_cyc(1, 16'h0303, 1);
      chk("b_occ1", b_occ, 1);
      chk("b_head", b_out_data, 16'h0202);
      b_cyc(1, 16'h0404, 0);
      chk("b_in_ready_bp", b_in_ready, 0);
      b_cyc(0, 0, 1);
      b_cyc(0, 0, 1);
      chk("b_occ0", b_occ, 0);

      // Saturation, reset mid-transfer, first accept after reset
      a_cyc(1, 16'h7777, 0, 0, 0);
      for (int i = 0; i < 70000; i++) a_cyc(0, 0, 0, 0, 0);
      chk("a_sat_stall", a_stall, 16'hFFFF);
      chk("a_sat_occ", a_occ, 1);
      do_reset();
      a_cyc(0, 0, 0, 0, 0);
      chk("a_post_rst_stall", a_stall, 0);
      chk("a_post_rst_occ", a_occ, 0);
      chk("a_post_rst_data", a_out_data, FV);
      a_cyc(1, 16'h8888, 1, 0, 0);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_post_rst_first", a_out_data, 16'h8888);
      chk("a_post_rst_occ1", a_occ, 1);
      a_cyc(0, 0, 1, 0, 0);
      chk("a_q_empty", a_q.size(), 0);
      chk("b_q_empty", b_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
